// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared constants for the two-requester register-bank arbiter.
//   DW   - register width (bits)
//   NIB  - nibble slice width
//   NNIB - nibble slices per register
//   NREG - registers in the bank, AW - register index width
//   IDLE / COMMIT - FSM state encoding
package reg_bank_pkg;
  localparam int DW   = 32;
  localparam int NIB  = 4;
  localparam int NNIB = DW / NIB;
  localparam int NREG = 4;
  localparam int AW   = $clog2(NREG);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] COMMIT = 1'b1;
endpackage

// File: rtl/nibble_reg.sv
// nibble_reg: one 4-bit storage slice of the register bank.
//   clk   - clock
//   reset - synchronous active-high reset to 0
//   clr   - synchronous clear to 0 (below reset in priority)
//   en    - load d at the edge
//   d     - write nibble
//   q     - stored nibble
module nibble_reg
  import reg_bank_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           en,
  input  logic [NIB-1:0] d,
  output logic [NIB-1:0] q
);
  logic [NIB-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)     q_d = '0;
    else if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin write arbiter for two requesters in front of a
// bank of NREG x DW registers built from nibble slices. A grant in IDLE latches
// the winner's addr/data/mask; the bank write lands on the following edge.
//   clk, reset      - clock, synchronous active-high reset
//   clr             - zero the whole bank; cancels a write in COMMIT
//   req[1:0]        - write requests, held until ack
//   addr0/1,d0/1    - per-requester register index and write data
//   mask0/1         - per-requester nibble write enables
//   ack[1:0]        - one-hot one-cycle grant pulse
//   wr_done         - one-cycle pulse after a committed write
//   busy            - high while in COMMIT
//   rd_addr, q      - combinational read port
module reg_bank_arbiter
  import reg_bank_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic [1:0]      req,
  input  logic [AW-1:0]   addr0,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   d0,
  input  logic [DW-1:0]   d1,
  input  logic [NNIB-1:0] mask0,
  input  logic [NNIB-1:0] mask1,
  output logic [1:0]      ack,
  output logic            wr_done,
  output logic            busy,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   q
);
  logic [0:0]      state_q, state_d;
  logic            last_q, last_d;
  logic [AW-1:0]   addr_h_q, addr_h_d;
  logic [DW-1:0]   d_h_q, d_h_d;
  logic [NNIB-1:0] mask_h_q, mask_h_d;
  logic [1:0]      ack_q, ack_d;
  logic            wr_done_q, wr_done_d;
  logic            win;

  logic [NIB-1:0]  bank_nib [NREG][NNIB];
  logic            nib_en   [NREG][NNIB];

  // Tie goes to whoever did not win last; otherwise the lone requester wins.
  assign win = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    addr_h_d  = addr_h_q;
    d_h_d     = d_h_q;
    mask_h_d  = mask_h_q;
    ack_d     = 2'b00;
    wr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          last_d     = win;
          addr_h_d   = win ? addr1 : addr0;
          d_h_d      = win ? d1    : d0;
          mask_h_d   = win ? mask1 : mask0;
          ack_d[win] = 1'b1;
          state_d    = COMMIT;
        end
      end
      COMMIT: begin
        // clr discards the pending write, so no completion is reported.
        wr_done_d = ~clr;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      addr_h_q  <= '0;
      d_h_q     <= '0;
      mask_h_q  <= '0;
      ack_q     <= 2'b00;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      addr_h_q  <= addr_h_d;
      d_h_q     <= d_h_d;
      mask_h_q  <= mask_h_d;
      ack_q     <= ack_d;
      wr_done_q <= wr_done_d;
    end
  end

  genvar r, n;
  generate
    for (r = 0; r < NREG; r++) begin : g_reg
      for (n = 0; n < NNIB; n++) begin : g_nib
        assign nib_en[r][n] = (state_q == COMMIT) && (addr_h_q == AW'(r)) && mask_h_q[n];
        nibble_reg u_nib (
          .clk   (clk),
          .reset (reset),
          .clr   (clr),
          .en    (nib_en[r][n]),
          .d     (d_h_q[n*NIB +: NIB]),
          .q     (bank_nib[r][n])
        );
      end
    end
  endgenerate

  always_comb begin
    q = '0;
    for (int k = 0; k < NNIB; k++) q[k*NIB +: NIB] = bank_nib[rd_addr][k];
  end

  assign ack     = ack_q;
  assign wr_done = wr_done_q;
  assign busy    = (state_q == COMMIT);
endmodule

// File: tb/tb_reg_bank_arbiter.sv
module tb_reg_bank_arbiter;
  logic        clk = 1'b0;
  logic        reset, clr;
  logic [1:0]  req;
  logic [1:0]  addr0, addr1, rd_addr;
  logic [31:0] d0, d1, q;
  logic [7:0]  mask0, mask1;
  logic [1:0]  ack;
  logic        wr_done, busy;

  int checks = 0;
  int errors = 0;

  reg_bank_arbiter dut (
    .clk(clk), .reset(reset), .clr(clr), .req(req),
    .addr0(addr0), .addr1(addr1), .d0(d0), .d1(d1),
    .mask0(mask0), .mask1(mask1), .ack(ack), .wr_done(wr_done),
    .busy(busy), .rd_addr(rd_addr), .q(q)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(tag, q, exp);
  endtask

  logic [1:0] exp_ack [8];

  initial begin
    exp_ack = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    reset = 1'b1; clr = 1'b0; req = 2'b11; rd_addr = 2'd0;
    addr0 = 2'd1; d0 = 32'hFFFFFFFF; mask0 = 8'hFF;
    addr1 = 2'd2; d1 = 32'h0BADF00D; mask1 = 8'h00;
    @(negedge clk);

    // Reset held two cycles with both requesting.
    cyc(); cyc();
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_wr_done", 32'(wr_done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 4; i++) rd(2'(i), "rst_q", 32'h0);

    // First tie after reset goes to requester 0 (also preloads bank[1]).
    reset = 1'b0;
    cyc();
    chk("first_tie_ack", 32'(ack), 32'h1);
    chk("first_tie_busy", 32'(busy), 32'h1);
    req = 2'b00;
    cyc();
    chk("first_tie_wr_done", 32'(wr_done), 32'h1);
    chk("first_tie_busy_lo", 32'(busy), 32'h0);
    rd(2'd1, "preload_q1", 32'hFFFFFFFF);
    rd(2'd2, "tie_loser_q2", 32'h0);

    // Single write from requester 0.
    req = 2'b01; addr0 = 2'd2; d0 = 32'hAFAFAFAF; mask0 = 8'hFF;
    cyc();
    chk("single_ack", 32'(ack), 32'h1);
    chk("single_wr_done_lo", 32'(wr_done), 32'h0);
    rd(2'd2, "single_q_old", 32'h0);
    req = 2'b00;
    cyc();
    chk("single_wr_done", 32'(wr_done), 32'h1);
    chk("single_ack_lo", 32'(ack), 32'h0);
    rd(2'd2, "single_q_new", 32'hAFAFAFAF);
    cyc();
    chk("single_wr_done_end", 32'(wr_done), 32'h0);

    // Nibble mask: clear low four nibbles of bank[1].
    req = 2'b10; addr1 = 2'd1; d1 = 32'h00000000; mask1 = 8'h0F;
    cyc();
    chk("mask_ack", 32'(ack), 32'h2);
    req = 2'b00;
    cyc();
    chk("mask_wr_done", 32'(wr_done), 32'h1);
    rd(2'd1, "mask_q", 32'hFFFF0000);

    // Empty mask: the transaction completes but nothing changes.
    req = 2'b10; d1 = 32'h12345678; mask1 = 8'h00;
    cyc();
    chk("mask0_ack", 32'(ack), 32'h2);
    req = 2'b00;
    cyc();
    chk("mask0_wr_done", 32'(wr_done), 32'h1);
    rd(2'd1, "mask0_q", 32'hFFFF0000);

    // Contention: requester 1 won last, so requester 0 takes the first tie.
    addr0 = 2'd0; d0 = 32'h11111111; mask0 = 8'hFF;
    addr1 = 2'd3; d1 = 32'h22222222; mask1 = 8'hFF;
    req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("cont_ack_%0d", i), 32'(ack), 32'(exp_ack[i]));
      chk($sformatf("cont_wr_done_%0d", i), 32'(wr_done), 32'(i % 2));
    end
    req = 2'b00;
    rd(2'd0, "cont_q0", 32'h11111111);
    rd(2'd3, "cont_q3", 32'h22222222);

    // clr in COMMIT discards the write and wipes the bank.
    req = 2'b01; addr0 = 2'd0; d0 = 32'h12345678; mask0 = 8'hFF;
    cyc();
    req = 2'b00;
    cyc();
    rd(2'd0, "pre_clr_q0", 32'h12345678);
    req = 2'b01; d0 = 32'hDEADBEEF;
    cyc();
    chk("clr_ack", 32'(ack), 32'h1);
    req = 2'b00; clr = 1'b1;
    cyc();
    chk("clr_wr_done", 32'(wr_done), 32'h0);
    chk("clr_busy", 32'(busy), 32'h0);
    rd(2'd0, "clr_q0", 32'h0);
    rd(2'd3, "clr_q3", 32'h0);

    // clr in IDLE still lets arbitration proceed.
    req = 2'b01; addr0 = 2'd2; d0 = 32'h00000055; mask0 = 8'hFF; clr = 1'b1;
    cyc();
    chk("clr_idle_ack", 32'(ack), 32'h1);
    clr = 1'b0; req = 2'b00;
    cyc();
    chk("clr_idle_wr_done", 32'(wr_done), 32'h1);
    rd(2'd2, "clr_idle_q2", 32'h00000055);

    // Reset during COMMIT loses the write and restores last=1.
    req = 2'b01; addr0 = 2'd3; d0 = 32'hFFFFFFFF;
    cyc();
    chk("rst_mid_ack", 32'(ack), 32'h1);
    req = 2'b00; reset = 1'b1;
    cyc();
    chk("rst_mid_wr_done", 32'(wr_done), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_ack_lo", 32'(ack), 32'h0);
    rd(2'd3, "rst_mid_q3", 32'h0);
    rd(2'd2, "rst_mid_q2", 32'h0);
    reset = 1'b0;
    req = 2'b11; addr0 = 2'd1; d0 = 32'hA5A5A5A5; addr1 = 2'd1; d1 = 32'h5A5A5A5A;
    cyc();
    chk("post_rst_tie_ack", 32'(ack), 32'h1);
    req = 2'b00;
    cyc();
    chk("post_rst_wr_done", 32'(wr_done), 32'h1);
    rd(2'd1, "post_rst_q1", 32'hA5A5A5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Two-requester write arbiter and sequencer for a bank of four 32-bit registers, each built from eight 4-bit nibble slices. It grants one requester per transaction using round-robin priority and captures that requester's address, data and nibble mask. The write is committed into the bank on the following cycle. It sits between producer blocks and the register bank, and exposes one combinational read port for consumers.

## Interface
- NREG, 4, number of 32-bit registers in the bank (address width 2)
- DW, 32, register width; must be a multiple of 4
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high; clears all state on the next posedge
- clr  in  1  synchronous clear of all bank registers
- req  in  2  per-requester write request; held until that requester's ack
- addr0, addr1  in  2 each  target register index for requester 0 / 1
- d0, d1  in  32 each  write data for requester 0 / 1
- mask0, mask1  in  8 each  nibble write-enables; bit k covers data bits 4k+3:4k
- ack  out  2  one-hot, one-cycle pulse: the request was captured
- wr_done  out  1  one-cycle pulse: the write was committed this cycle
- busy  out  1  high while in COMMIT
- rd_addr  in  2  read index
- q  out  32  combinational read of bank[rd_addr]

## Operation
- **FSM states:** IDLE, COMMIT.
- **IDLE:**
  - If req==0, stay in IDLE.
  - Otherwise select a winner:
    - If only one requester asserts req, that requester wins.
    - If both assert req, the requester other than `last` wins.
  - Latch the winner's addr, d and mask into holding registers.
  - Set `last` to the winner.
  - Register ack[winner]=1.
  - Go to COMMIT.
- **COMMIT:**
  - For every k with mask_h[k]=1, bank[addr_h] nibble k takes d_h nibble k. Other nibbles hold.
  - Register wr_done=1.
  - Return to IDLE.
- **clr:**
  - In any state, clr=1 zeroes all bank registers at the edge.
  - In COMMIT, clr overrides the pending write: the write is discarded, wr_done stays 0, and the FSM still returns to IDLE.
  - In IDLE, clr does not block arbitration.
- **mask=8'h00:** the transaction still runs (ack, then wr_done) but the bank is unchanged.
- **Requester obligation:** drop req, or present a new transaction, in the cycle ack is seen. A req still high in the next IDLE cycle is treated as a new request.
- **Reset values:**
  - state=IDLE
  - ack=2'b00, wr_done=0, busy=0
  - all bank registers 0, so q=0
  - last=1, so requester 0 wins the first tie
  - holding registers 0

## Timing
- **Request to commit:**
  - req sampled high in IDLE at edge t.
  - ack is high during cycle t..t+1.
  - The bank write occurs at edge t+1.
  - wr_done is high during cycle t+1..t+2.
  - q reflects the new value from edge t+1.
- **Throughput:** one write per 2 cycles. Under continuous contention the grants alternate 0,1,0,1.
- **q latency:** 0 cycles from rd_addr; purely combinational from the bank.
- **Bank conflict:** a read of the register being written returns the old value until edge t+1.
- **reset vs clr:** reset has priority over clr. Both act at the same edge.
- **Reset mid-COMMIT:** the pending write is lost, wr_done=0, and all outputs return to reset values at that edge.

## Structure
- **Shared package (reg_bank_pkg):**
  - DW=32, NIB=4, NNIB=DW/NIB=8, NREG=4
  - FSM state encoding: IDLE=1'b0, COMMIT=1'b1
- **Sub-module nibble_reg (4-bit):**
  - Ports: clk, reset, clr, en, d[3:0], q[3:0].
  - Synchronous active-high reset and clr; loads d when en.
  - Instantiated with a generate loop: NREG×NNIB = 32 instances.
- The top level contains the arbiter, FSM, holding registers, enable decode (addr_h × mask_h gated by COMMIT) and the read mux.

## Test plan
- **Reset:** assert reset 2 cycles with req=2'b11 -> ack=0, wr_done=0, q=0 for every rd_addr. After release, the first grant goes to requester 0.
- **Single write:** req=2'b01, addr0=2, d0=32'hAFAFAFAF, mask0=8'hFF -> ack=2'b01 one cycle, then wr_done=1 one cycle. rd_addr=2 gives q=32'hAFAFAFAF from the commit edge.
- **Nibble mask:**
  - bank[1]=32'hFFFFFFFF.
  - Write d1=32'h00000000, mask1=8'h0F -> q=32'hFFFF0000.
  - Write mask=8'h00 -> wr_done pulses and q is unchanged.
- **Contention:** req=2'b11 held for 8 cycles, with addr0=0, d0=32'h11111111 and addr1=3, d1=32'h22222222 -> ack sequence 01,10,01,10, each separated by one idle cycle. bank[0] and bank[3] hold their respective values.
- **clr during COMMIT:** bank[0]=32'h12345678, then a write of 32'hDEADBEEF to addr 0 with clr=1 in its COMMIT cycle -> wr_done=0 and bank[0]=0.
- **Reset mid-operation:** reset=1 in the COMMIT cycle of a write of 32'hFFFFFFFF to addr 3 -> bank[3]=0, busy=0, state IDLE. The next tie is won by requester 0.
